// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt controller core: FSM states,
// default sizing and the rotating-priority rank function.
package pic_pkg;

  localparam int PIC_NUM_IR = 8;
  localparam int PIC_VEC_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } pic_state_e;

  // Rank 0 is the highest priority; lp is the current lowest-priority line.
  function automatic int rank(input int i, input int lp, input int n);
    return (i - lp - 1 + n) % n;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Combinational rotating-priority resolver with in-service nesting: picks the
// best pending line whose rank beats every in-service line.
module priority_resolver
  import pic_pkg::*;
#(
  parameter int  NUM_IR = PIC_NUM_IR,
  localparam int IDX_W  = $clog2(NUM_IR)
) (
  input  logic [NUM_IR-1:0] pending,
  input  logic [NUM_IR-1:0] ISR,
  input  logic [IDX_W-1:0]  lp,
  output logic [IDX_W-1:0]  winner,
  output logic              winnerValid,
  output logic [IDX_W-1:0]  isrHighest
);

  int win_rank;
  int isr_rank;
  int r;

  always_comb begin
    win_rank   = NUM_IR;
    isr_rank   = NUM_IR;
    r          = 0;
    winner     = '0;
    isrHighest = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      r = rank(i, int'(lp), NUM_IR);
      if (ISR[i] && (r < isr_rank)) begin
        isr_rank   = r;
        isrHighest = IDX_W'(i);
      end
      if (pending[i] && (r < win_rank)) begin
        win_rank = r;
        winner   = IDX_W'(i);
      end
    end
    // Equal rank to an in-service line is blocked, so strictly less-than.
    winnerValid = (win_rank < isr_rank);
  end

endmodule

// File: rtl/interrupt_controller_core.sv
// PIC interrupt core: IRR capture, masking, nested/rotating priority, the
// two-pulse INTA vector handshake and ISR maintenance (EOI / AEOI).
module interrupt_controller_core
  import pic_pkg::*;
#(
  parameter int  NUM_IR = PIC_NUM_IR,
  parameter int  VEC_W  = PIC_VEC_W,
  localparam int IDX_W  = $clog2(NUM_IR)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IR-1:0]      IRBus,
  input  logic                   LTIM,
  input  logic                   AR,
  input  logic                   AEOI,
  input  logic [VEC_W-IDX_W-1:0] TReg,
  input  logic [NUM_IR-1:0]      IMR,
  input  logic                   INTA,
  input  logic                   eoiStrobe,
  input  logic                   eoiSpecific,
  input  logic [IDX_W-1:0]       eoiLevel,
  output logic                   INT,
  output logic [VEC_W-1:0]       vector,
  output logic                   vectorValid,
  output logic [NUM_IR-1:0]      IRR,
  output logic [NUM_IR-1:0]      ISR
);

  pic_state_e        state_q, state_d;
  logic [NUM_IR-1:0] ir_q, ir_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [IDX_W-1:0]  lp_q, lp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              spur_q, spur_d;
  logic [VEC_W-1:0]  vector_q, vector_d;
  logic              vv_q, vv_d;
  logic              inta_q, inta_d;

  logic [IDX_W-1:0]  sel_winner, eoi_winner;
  logic              sel_valid, eoi_valid;
  logic [IDX_W-1:0]  sel_isr_top, eoi_isr_top;
  logic [NUM_IR-1:0] ack_mask;
  logic              inta_fall, first_ack, second_ack;
  logic              unused_resolver_bits;

  priority_resolver #(.NUM_IR(NUM_IR)) u_sel (
    .pending     (irr_q & ~IMR),
    .ISR         (isr_q),
    .lp          (lp_q),
    .winner      (sel_winner),
    .winnerValid (sel_valid),
    .isrHighest  (sel_isr_top)
  );

  // With pending=ISR and nothing blocking, the winner is the top in-service line.
  priority_resolver #(.NUM_IR(NUM_IR)) u_eoi (
    .pending     (isr_q),
    .ISR         ('0),
    .lp          (lp_q),
    .winner      (eoi_winner),
    .winnerValid (eoi_valid),
    .isrHighest  (eoi_isr_top)
  );

  assign unused_resolver_bits = ^{sel_isr_top, eoi_isr_top};

  // Handshake: INT stays high in REQ until the first INTA falling edge claims
  // the winner; the second falling edge in ACK delivers vector with a one-cycle
  // vectorValid pulse. Edges seen in IDLE are ignored.
  assign inta_d     = INTA;
  assign inta_fall  = inta_q & ~INTA;
  assign first_ack  = (state_q == REQ) && inta_fall;
  assign second_ack = (state_q == ACK) && inta_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      lp_q     <= IDX_W'(NUM_IR - 1);
      idx_q    <= '0;
      spur_q   <= 1'b0;
      vector_q <= '0;
      vv_q     <= 1'b0;
      inta_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      lp_q     <= lp_d;
      idx_q    <= idx_d;
      spur_q   <= spur_d;
      vector_q <= vector_d;
      vv_q     <= vv_d;
      inta_q   <= inta_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_valid) state_d = REQ;
      REQ: begin
        if (inta_fall)       state_d = ACK;
        else if (!sel_valid) state_d = IDLE;
      end
      ACK:     if (inta_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    INT = (state_q == REQ);
  end

  always_comb begin
    ir_d     = IRBus;
    idx_d    = idx_q;
    spur_d   = spur_q;
    isr_d    = isr_q;
    lp_d     = lp_q;
    vector_d = vector_q;
    vv_d     = second_ack;
    ack_mask = '0;

    if (first_ack) begin
      idx_d  = sel_valid ? sel_winner : '1;
      spur_d = !sel_valid;
      if (sel_valid) ack_mask[sel_winner] = 1'b1;
    end

    // A fresh rising edge wins over an acknowledge clearing the same bit.
    if (LTIM) irr_d = IRBus;
    else      irr_d = (IRBus & ~ir_q) | (irr_q & IRBus & ~ack_mask);

    // EOI acts on the pre-edge ISR; a same-cycle acknowledge still sets its bit.
    if (eoiStrobe) begin
      if (eoiSpecific) begin
        isr_d[eoiLevel] = 1'b0;
      end else if (eoi_valid) begin
        isr_d[eoi_winner] = 1'b0;
        if (AR) lp_d = eoi_winner;
      end
    end
    if (first_ack && sel_valid) isr_d[sel_winner] = 1'b1;

    if (second_ack) begin
      vector_d = {TReg, idx_q};
      if (AEOI && !spur_q) begin
        isr_d[idx_q] = 1'b0;
        if (AR) lp_d = idx_q;
      end
    end
  end

  assign vector      = vector_q;
  assign vectorValid = vv_q;
  assign IRR         = irr_q;
  assign ISR         = isr_q;

endmodule
